// File: rtl/upload_req_arb_if.sv
// Upload request arbiter bus interface.
// Bundles the two requester packet ports, the downstream request FIFO
// handshake and the arbiter status outputs. The arbiter uses the master
// modport. Requesters and the FIFO together form the slave side.
interface upload_req_arb_if;
   logic [47:0] ic_flits_req;
   logic        v_ic_flits_req;
   logic [47:0] dc_flits_req;
   logic        v_dc_flits_req;
   logic        req_fifo_rdy;
   logic [15:0] flit_out;
   logic        v_flit_out;
   logic        flit_src;
   logic        flit_tail;
   logic        ic_req_ack;
   logic        dc_req_ack;
   logic        arb_busy;

   modport master (
      input  ic_flits_req,
      input  v_ic_flits_req,
      input  dc_flits_req,
      input  v_dc_flits_req,
      input  req_fifo_rdy,
      output flit_out,
      output v_flit_out,
      output flit_src,
      output flit_tail,
      output ic_req_ack,
      output dc_req_ack,
      output arb_busy
   );

   modport slave (
      output ic_flits_req,
      output v_ic_flits_req,
      output dc_flits_req,
      output v_dc_flits_req,
      output req_fifo_rdy,
      input  flit_out,
      input  v_flit_out,
      input  flit_src,
      input  flit_tail,
      input  ic_req_ack,
      input  dc_req_ack,
      input  arb_busy
   );
endinterface

// File: rtl/upload_req_arb.sv
// Upload request arbiter.
// Two requesters (IC and DC) each offer a 3-flit, 48-bit packet. One packet
// is latched at a time and then streamed flit by flit into the downstream
// request FIFO, stalling whenever the FIFO is not ready.
// Simultaneous requests are normally resolved round-robin. Defining the
// macro UPLOAD_ARB_FIXED_PRIO_EN gives IC fixed priority instead, in which
// case the round-robin pointer and RR_INIT are not used.
module upload_req_arb #(
   parameter logic RR_INIT = 1'b0
) (
   input logic              clk,
   input logic              rst,
   upload_req_arb_if.master bus
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [47:0] pkt;
   logic [47:0] pkt_next;
   logic [1:0]  cnt;
   logic [1:0]  cnt_next;
   logic        src;
   logic        src_next;
   logic        grant_ic;
   logic        grant_dc;
   logic        tail_xfer;
`ifndef UPLOAD_ARB_FIXED_PRIO_EN
   logic        rr_ptr;
`endif

   // Pick which requester wins in IDLE; a lone request always wins
   always_comb begin
      grant_ic = 1'b0;
      grant_dc = 1'b0;
      if (state == IDLE) begin
         if (bus.v_ic_flits_req && bus.v_dc_flits_req) begin
`ifdef UPLOAD_ARB_FIXED_PRIO_EN
            grant_ic = 1'b1;
`else
            if (rr_ptr) begin
               grant_dc = 1'b1;
            end else begin
               grant_ic = 1'b1;
            end
`endif
         end else if (bus.v_ic_flits_req) begin
            grant_ic = 1'b1;
         end else if (bus.v_dc_flits_req) begin
            grant_dc = 1'b1;
         end
      end
   end

   // Next-state logic and all outputs; IDLE keeps the flit outputs at zero
   always_comb begin
      state_next      = state;
      pkt_next        = pkt;
      cnt_next        = cnt;
      src_next        = src;
      tail_xfer       = 1'b0;
      bus.flit_out    = 16'h0000;
      bus.v_flit_out  = 1'b0;
      bus.flit_src    = 1'b0;
      bus.flit_tail   = 1'b0;
      bus.ic_req_ack  = 1'b0;
      bus.dc_req_ack  = 1'b0;
      bus.arb_busy    = 1'b0;
      case (state)
         IDLE: begin
            bus.ic_req_ack = grant_ic;
            bus.dc_req_ack = grant_dc;
            if (grant_ic || grant_dc) begin
               pkt_next   = grant_ic ? bus.ic_flits_req : bus.dc_flits_req;
               src_next   = grant_dc;
               cnt_next   = 2'd0;
               state_next = BUSY;
            end
         end
         BUSY: begin
            bus.arb_busy   = 1'b1;
            bus.flit_src   = src;
            bus.v_flit_out = bus.req_fifo_rdy;
            case (cnt)
               2'd1:    bus.flit_out = pkt[31:16];
               2'd2:    bus.flit_out = pkt[15:0];
               default: bus.flit_out = pkt[47:32];
            endcase
            if (bus.req_fifo_rdy) begin
               cnt_next = cnt + 2'd1;
               if (cnt == 2'd2) begin
                  bus.flit_tail = 1'b1;
                  tail_xfer     = 1'b1;
                  state_next    = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, packet, flit counter and source registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pkt   <= 48'h0;
         cnt   <= 2'd0;
         src   <= 1'b0;
      end else begin
         state <= state_next;
         pkt   <= pkt_next;
         cnt   <= cnt_next;
         src   <= src_next;
      end
   end

`ifndef UPLOAD_ARB_FIXED_PRIO_EN
   // After each tail transfer, favour the requester that was not just served
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= RR_INIT;
      end else if (tail_xfer) begin
         rr_ptr <= ~src;
      end
   end
`endif

endmodule

// File: tb/tb_upload_req_arb.sv
// Testbench for upload_req_arb (default round-robin build, RR_INIT = 0).
// Requester driver processes hold valid until acked; the test sequence
// pushes hand-computed acks and flits into scoreboard queues and a monitor
// process checks them as the DUT presents them.
module tb_upload_req_arb;

   logic clk;
   logic rst;

   upload_req_arb_if bus();

   upload_req_arb #(.RR_INIT(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0] data;
      logic        src;
      logic        tail;
      int          delta;
   } flit_exp_t;

   typedef struct {
      logic src;
      int   delta;
   } ack_exp_t;

   flit_exp_t   flit_q[$];
   ack_exp_t    ack_q[$];
   logic [47:0] ic_q[$];
   logic [47:0] dc_q[$];

   int n_compared    = 0;
   int n_mismatched  = 0;
   int cyc           = 0;
   int last_ack_cyc  = 0;
   int last_tail_cyc = 0;

   localparam bit [4:0] RDY_PAT = 5'b10011;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter used for latency checks
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [47:0] got, input logic [47:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input bit which, input logic [47:0] pkt);
      if (which) dc_q.push_back(pkt);
      else       ic_q.push_back(pkt);
   endtask

   task automatic expectAck(input logic s, input int delta);
      ack_exp_t a;
      a.src   = s;
      a.delta = delta;
      ack_q.push_back(a);
   endtask

   task automatic expectFlit(input logic [15:0] d, input logic s, input logic t, input int delta);
      flit_exp_t f;
      f.data  = d;
      f.src   = s;
      f.tail  = t;
      f.delta = delta;
      flit_q.push_back(f);
   endtask

   task automatic expectPacket(input logic s, input logic [47:0] pkt, input int ack_delta,
                               input int d0, input int d1, input int d2);
      expectAck(s, ack_delta);
      expectFlit(pkt[47:32], s, 1'b0, d0);
      expectFlit(pkt[31:16], s, 1'b0, d1);
      expectFlit(pkt[15:0],  s, 1'b1, d2);
   endtask

   function automatic logic [47:0] mkPkt(input logic [15:0] base, input int k);
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      a = base + 16'(k);
      b = base + 16'h0100 + 16'(k);
      c = base + 16'h0200 + 16'(k);
      return {a, b, c};
   endfunction

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_v_flit_out"}, bus.v_flit_out, 1'b0);
      checkOutput({tag, "_flit_out"},   bus.flit_out, 16'h0000);
      checkOutput({tag, "_flit_tail"},  bus.flit_tail, 1'b0);
      checkOutput({tag, "_ic_ack"},     bus.ic_req_ack, 1'b0);
      checkOutput({tag, "_dc_ack"},     bus.dc_req_ack, 1'b0);
      checkOutput({tag, "_arb_busy"},   bus.arb_busy, 1'b0);
   endtask

   task automatic resetDut();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkIdle("reset");
      checkOutput("reset_flit_src", bus.flit_src, 1'b0);
   endtask

   task automatic waitAck(input bit which);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (which ? bus.dc_req_ack : bus.ic_req_ack) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("ack_wait", seen, 1'b1);
   endtask

   task automatic waitDrain(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (flit_q.size() == 0 && ack_q.size() == 0 && ic_q.size() == 0 &&
             dc_q.size() == 0 && !bus.arb_busy &&
             !bus.v_ic_flits_req && !bus.v_dc_flits_req) begin
            done = 1'b1;
            break;
         end
      end
      checkOutput({tag, "_drain"}, done, 1'b1);
      checkIdle(tag);
   endtask

   // IC requester: present queued packets, drop valid after the ack edge
   initial begin : ic_driver
      bit acked;
      bus.ic_flits_req   = 48'h0;
      bus.v_ic_flits_req = 1'b0;
      forever begin
         @(negedge clk);
         acked = bus.ic_req_ack;
         @(posedge clk);
         #1;
         if (acked) begin
            bus.v_ic_flits_req = 1'b0;
            bus.ic_flits_req   = 48'h0;
         end
         if (!bus.v_ic_flits_req && ic_q.size() > 0) begin
            bus.ic_flits_req   = ic_q.pop_front();
            bus.v_ic_flits_req = 1'b1;
         end
      end
   end

   // DC requester: same handshake as the IC side
   initial begin : dc_driver
      bit acked;
      bus.dc_flits_req   = 48'h0;
      bus.v_dc_flits_req = 1'b0;
      forever begin
         @(negedge clk);
         acked = bus.dc_req_ack;
         @(posedge clk);
         #1;
         if (acked) begin
            bus.v_dc_flits_req = 1'b0;
            bus.dc_flits_req   = 48'h0;
         end
         if (!bus.v_dc_flits_req && dc_q.size() > 0) begin
            bus.dc_flits_req   = dc_q.pop_front();
            bus.v_dc_flits_req = 1'b1;
         end
      end
   end

   // Monitor: compare every ack and flit against the scoreboard queues
   initial begin : monitor
      ack_exp_t  a;
      flit_exp_t f;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.ic_req_ack || bus.dc_req_ack) begin
               checkOutput("single_ack", bus.ic_req_ack & bus.dc_req_ack, 1'b0);
               checkOutput("ack_expected", ack_q.size() != 0, 1'b1);
               if (ack_q.size() != 0) begin
                  a = ack_q.pop_front();
                  checkOutput("ack_src", bus.dc_req_ack, a.src);
                  if (a.delta >= 0)
                     checkOutput("ack_after_tail", cyc - last_tail_cyc, a.delta);
               end
               last_ack_cyc = cyc;
            end
            if (bus.v_flit_out) begin
               checkOutput("flit_expected", flit_q.size() != 0, 1'b1);
               if (flit_q.size() != 0) begin
                  f = flit_q.pop_front();
                  checkOutput("flit_data", bus.flit_out, f.data);
                  checkOutput("flit_src",  bus.flit_src, f.src);
                  checkOutput("flit_tail", bus.flit_tail, f.tail);
                  if (f.delta >= 0)
                     checkOutput("flit_after_ack", cyc - last_ack_cyc, f.delta);
               end
               if (bus.flit_tail) last_tail_cyc = cyc;
            end else if (bus.arb_busy && flit_q.size() != 0) begin
               checkOutput("stall_hold", bus.flit_out, flit_q[0].data);
            end
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      rst              = 1'b1;
      bus.req_fifo_rdy = 1'b1;
      resetDut();

      $display("[TB] single IC packet");
      applyStimulus(1'b0, 48'hAAAA_BBBB_CCCC);
      expectPacket(1'b0, 48'hAAAA_BBBB_CCCC, -1, 1, 2, 3);
      waitDrain("t1");

      $display("[TB] simultaneous IC and DC after reset");
      resetDut();
      applyStimulus(1'b0, 48'h1111_2222_3333);
      applyStimulus(1'b1, 48'h4444_5555_6666);
      expectPacket(1'b0, 48'h1111_2222_3333, -1, 1, 2, 3);
      expectPacket(1'b1, 48'h4444_5555_6666, 1, 1, 2, 3);
      waitDrain("t2");

      $display("[TB] DC packet with FIFO stalls");
      applyStimulus(1'b1, 48'hDEAD_BEEF_CAFE);
      expectPacket(1'b1, 48'hDEAD_BEEF_CAFE, -1, 1, 4, 5);
      waitAck(1'b1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 bus.req_fifo_rdy = RDY_PAT[4 - i];
      end
      waitDrain("t3");

      $display("[TB] both requesters continuously valid");
      resetDut();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, mkPkt(16'h1A00, k));
         applyStimulus(1'b1, mkPkt(16'h2A00, k));
      end
      for (int k = 0; k < 4; k++) begin
         expectPacket(1'b0, mkPkt(16'h1A00, k), (k == 0) ? -1 : 1, 1, 2, 3);
         expectPacket(1'b1, mkPkt(16'h2A00, k), 1, 1, 2, 3);
      end
      waitDrain("t4");

      $display("[TB] reset while a packet is in flight");
      applyStimulus(1'b0, 48'h0123_4567_89AB);
      expectAck(1'b0, -1);
      expectFlit(16'h0123, 1'b0, 1'b0, 1);
      waitAck(1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst              = 1'b1;
      bus.req_fifo_rdy = 1'b0;
      @(posedge clk);
      #1;
      rst              = 1'b0;
      bus.req_fifo_rdy = 1'b1;
      @(negedge clk);
      checkIdle("t5_post_reset");
      checkOutput("t5_flit_q_empty", flit_q.size(), 0);
      applyStimulus(1'b0, 48'h0F0F_1E1E_2D2D);
      expectPacket(1'b0, 48'h0F0F_1E1E_2D2D, -1, 1, 2, 3);
      waitDrain("t5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/upload_req_arb.md
UPLOAD_REQ_ARB -- requirements
Module: upload_req_arb

Interface
REQ-001 SHALL provide parameter: RR_INIT, 1'b0, initial round-robin favoured requester after reset (0 = IC, 1 = DC).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: ic_flits_req  input  48  IC request packet; flit0 = [47:32], flit1 = [31:16], flit2 = [15:0].
REQ-005 SHALL have port: v_ic_flits_req  input  1  IC packet valid; held by requester until ic_req_ack.
REQ-006 SHALL have port: dc_flits_req  input  48  DC request packet; same flit ordering as IC.
REQ-007 SHALL have port: v_dc_flits_req  input  1  DC packet valid; held by requester until dc_req_ack.
REQ-008 SHALL have port: req_fifo_rdy  input  1  downstream request FIFO can accept one flit this cycle.
REQ-009 SHALL have port: flit_out  output  16  current flit to request FIFO.
REQ-010 SHALL have port: v_flit_out  output  1  flit_out valid; the FIFO writes when high.
REQ-011 SHALL have port: flit_src  output  1  source of the packet in flight (0 = IC, 1 = DC).
REQ-012 SHALL have port: flit_tail  output  1  high with the last flit (flit2) of a packet.
REQ-013 SHALL have port: ic_req_ack  output  1  one-cycle pulse: IC packet latched.
REQ-014 SHALL have port: dc_req_ack  output  1  one-cycle pulse: DC packet latched.
REQ-015 SHALL have port: arb_busy  output  1  high while a packet is held or being sent.

Function
REQ-016 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-017 In IDLE with exactly one valid asserted, SHALL latch that packet, pulse its ack combinationally that cycle, record flit_src, clear flit counter, and enter BUSY next cycle.
REQ-018 In IDLE with both valids asserted, SHALL grant the requester named by the round-robin pointer; the other SHALL receive no ack.
REQ-019 In BUSY, SHALL drive v_flit_out = req_fifo_rdy combinationally; flit_out SHALL select flit0/1/2 by a 2-bit counter, with counter value 3 mapping to flit0.
REQ-020 Each cycle with v_flit_out high, the counter SHALL increment; with counter == 2, flit_tail SHALL be high and FSM SHALL return to IDLE next cycle.
REQ-021 With req_fifo_rdy low in BUSY, SHALL hold the counter and packet; flit_out SHALL stay stable; no flit is lost or duplicated.
REQ-022 On tail-flit transfer, round-robin pointer SHALL be set to favour the requester not just served.
REQ-023 Requests in BUSY SHALL NOT be acked; the earliest new grant is the cycle after the tail transfer, so back-to-back packets take 3 + 1 cycles minimum.
REQ-024 In IDLE, v_flit_out, flit_tail, and both acks SHALL be 0; flit_out SHALL be 16'h0000.
REQ-025 arb_busy SHALL equal (state == BUSY).

Reset
REQ-026 On rst, SHALL force IDLE, counter = 0, packet register = 48'h0, flit_src = 0, and pointer = RR_INIT, overriding any other update that cycle.
REQ-027 rst during BUSY SHALL discard the packet in flight with no further flits; the requester is not re-acked.
REQ-028 All outputs SHALL be 0 in the cycle after rst is sampled.

Configuration
REQ-029 With macro UPLOAD_ARB_FIXED_PRIO_EN defined, IC SHALL always win simultaneous requests, and the pointer and RR_INIT SHALL be unused.
REQ-030 Without UPLOAD_ARB_FIXED_PRIO_EN, round-robin per REQ-018/REQ-022 SHALL apply.

Verification
REQ-031 IC only, packet 48'hAAAA_BBBB_CCCC, rdy = 1 -> ic_req_ack at cycle 0; flits AAAA, BBBB, CCCC on cycles 1-3; tail at cycle 3; flit_src = 0.
REQ-032 IC and DC valid together after reset, RR_INIT = 0 -> IC served first, then DC acked the cycle after the IC tail; DC flits carry flit_src = 1.
REQ-033 rdy pattern 1,0,0,1,1 during a DC packet -> flit1 held stable over the stall cycles; exactly 3 valid flits; tail on the last valid flit.
REQ-034 Both requesters continuously valid for 4 packets -> grant order IC, DC, IC, DC (DC, IC, DC, IC with RR_INIT = 1); with UPLOAD_ARB_FIXED_PRIO_EN -> IC, IC, IC, IC.
REQ-035 rst asserted after flit0 sent -> next cycle IDLE, v_flit_out = 0, arb_busy = 0; a subsequent request restarts from flit0.
